kairo_divider_pipe: RTL

//  Parametrised iterative integer divider for RV32M/RV64M DIV/DIVU/REM/REMU.

---
 rtl/kairo_divider_pipe.sv | 121 ++++++++++++
 1 files changed

// File: rtl/kairo_divider_pipe.sv
// kairo_divider_pipe: iterative restoring divider for RV32M/RV64M DIV/DIVU/REM/REMU.
//   CLK, RST_N (sync, active-low)
//   REQ_VALID/REQ_READY, REQ_OP (00 DIV, 01 DIVU, 10 REM, 11 REMU), RS1 dividend, RS2 divisor
//   KILL aborts any operation and drops a pending result
//   RESP_VALID/RESP_READY, RESP_DATA quotient or remainder; BUSY while not idle
module kairo_divider_pipe #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [1:0]      REQ_OP,
    input  logic [XLEN-1:0] RS1,
    input  logic [XLEN-1:0] RS2,
    input  logic            KILL,
    output logic            RESP_VALID,
    input  logic            RESP_READY,
    output logic [XLEN-1:0] RESP_DATA,
    output logic            BUSY
);
    localparam int STEPS = XLEN / BPC;
    localparam int CW = $clog2(STEPS + 1);
    localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2;
    logic [1:0] state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, res_q, res_d;
    logic is_rem_q, is_rem_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic [XLEN-1:0] quo_s, rem_s, quo_fix, rem_fix, abs1, abs2;
    logic [XLEN:0] trial;
    logic sgn, div0, ovf;
    // quo_q doubles as the dividend shift register: its MSB feeds the partial
    // remainder while quotient bits enter at the LSB.
    always_comb begin
        quo_s = quo_q;
        rem_s = rem_q;
        trial = '0;
        for (int i = 0; i < BPC; i++) begin
            trial = {rem_s, quo_s[XLEN-1]};
            quo_s = {quo_s[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, dvs_q}) begin
                trial = trial - {1'b0, dvs_q};
                quo_s[0] = 1'b1;
            end
            rem_s = trial[XLEN-1:0];
        end
    end
    always_comb begin
        sgn = ~REQ_OP[0];
        abs1 = (sgn & RS1[XLEN-1]) ? -RS1 : RS1;
        abs2 = (sgn & RS2[XLEN-1]) ? -RS2 : RS2;
        div0 = RS2 == '0;
        ovf = sgn && RS1 == {1'b1, {(XLEN-1){1'b0}}} && &RS2;
        quo_fix = qneg_q ? -quo_s : quo_s;
        rem_fix = rneg_q ? -rem_s : rem_s;
        state_d = state_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        res_d = res_q;
        is_rem_d = is_rem_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (KILL) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (REQ_VALID) begin
                    quo_d = abs1;
                    rem_d = '0;
                    dvs_d = abs2;
                    is_rem_d = REQ_OP[1];
                    qneg_d = sgn & (RS1[XLEN-1] ^ RS2[XLEN-1]);
                    rneg_d = sgn & RS1[XLEN-1];
                    cnt_d = CW'(STEPS);
                    state_d = (div0 | ovf) ? DONE : EXEC;
                    // Early-out results are written directly; no iteration needed.
                    res_d = div0 ? (REQ_OP[1] ? RS1 : '1) : ovf ? (REQ_OP[1] ? '0 : RS1) : res_q;
                end
                EXEC: begin
                    quo_d = quo_s;
                    rem_d = rem_s;
                    cnt_d = cnt_q - CW'(1);
                    state_d = (cnt_q == CW'(1)) ? DONE : EXEC;
                    res_d = (cnt_q == CW'(1)) ? (is_rem_q ? rem_fix : quo_fix) : res_q;
                end
                DONE: state_d = RESP_READY ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            res_q <= '0;
            is_rem_q <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            res_q <= res_d;
            is_rem_q <= is_rem_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
    assign REQ_READY = state_q == IDLE;
    assign RESP_VALID = state_q == DONE;
    assign BUSY = state_q != IDLE;
    assign RESP_DATA = res_q;
endmodule
